// File: rtl/fft128_frame_ctrl_if.sv
// Stream bundle around the frame controller: RX samples in, FFT sink out,
// FFT source in and tracked output stream out.
interface fft128_frame_ctrl_if #(
   parameter int N = 128,
   parameter int W = 12
);
   localparam int BW = $clog2(N);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_real;
   logic [W-1:0]  in_imag;

   logic          fft_sink_valid;
   logic          fft_sink_ready;
   logic          fft_sink_sop;
   logic          fft_sink_eop;
   logic [1:0]    fft_sink_error;
   logic [W-1:0]  fft_sink_real;
   logic [W-1:0]  fft_sink_imag;
   logic          fft_inverse;

   logic          fft_source_valid;
   logic          fft_source_ready;
   logic [1:0]    fft_source_error;
   logic          fft_source_sop;
   logic          fft_source_eop;
   logic [W-1:0]  fft_source_real;
   logic [W-1:0]  fft_source_imag;
   logic [5:0]    fft_source_exp;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_real;
   logic [W-1:0]  out_imag;
   logic [5:0]    out_exp;
   logic [BW-1:0] out_bin;
   logic          out_sop;
   logic          out_eop;

   // The frame controller itself uses the slave view; its environment uses master.
   modport slave (
      input  in_valid, in_real, in_imag,
      output in_ready,
      output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
      output fft_sink_real, fft_sink_imag, fft_inverse,
      input  fft_sink_ready,
      input  fft_source_valid, fft_source_error, fft_source_sop, fft_source_eop,
      input  fft_source_real, fft_source_imag, fft_source_exp,
      output fft_source_ready,
      output out_valid, out_real, out_imag, out_exp, out_bin, out_sop, out_eop,
      input  out_ready
   );

   modport master (
      output in_valid, in_real, in_imag,
      input  in_ready,
      input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
      input  fft_sink_real, fft_sink_imag, fft_inverse,
      output fft_sink_ready,
      output fft_source_valid, fft_source_error, fft_source_sop, fft_source_eop,
      output fft_source_real, fft_source_imag, fft_source_exp,
      input  fft_source_ready,
      input  out_valid, out_real, out_imag, out_exp, out_bin, out_sop, out_eop,
      output out_ready
   );
endinterface

// File: rtl/fft128_frame_ctrl.sv
// Frame sequencer and output tracker for the 128-point streaming FFT core:
// frames the RX stream into the core and numbers/validates the core's output.
module fft128_frame_ctrl #(
   parameter int N = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_cfg_enable,
   input  logic                 i_cfg_inverse,
   input  logic                 i_err_clr,
   fft128_frame_ctrl_if.slave   bus,
   output logic [15:0]          o_frames_in,
   output logic [15:0]          o_frames_out,
   output logic                 o_frame_err,
   output logic                 o_err_sticky,
   output logic                 o_busy
);
   localparam int BW = $clog2(N);
   localparam logic [BW-1:0] LAST = BW'(N - 1);

   typedef enum logic {IDLE, FRAME} state_t;

   state_t        r_state, w_next_state;
   logic [BW-1:0] r_icnt, r_ocnt;
   logic          r_inverse;
   logic [5:0]    r_exp;
   logic [15:0]   r_frames_in, r_frames_out;
   logic          r_frame_err, r_err_sticky;

   logic          w_in_xfer, w_in_last, w_start;
   logic          w_out_xfer, w_framing_err, w_err, w_frame_done;
   logic [BW-1:0] w_out_bin;

   assign w_in_xfer = (r_state == FRAME) & bus.in_valid & bus.fft_sink_ready & ~reset;
   assign w_in_last = (r_icnt == LAST);

   always_comb begin
      w_next_state        = r_state;
      w_start             = 1'b0;
      bus.in_ready        = 1'b0;
      bus.fft_sink_valid  = 1'b0;
      bus.fft_sink_sop    = 1'b0;
      bus.fft_sink_eop    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_cfg_enable) begin
               w_next_state = FRAME;
               w_start      = 1'b1;
            end
         end
         FRAME: begin
            bus.in_ready       = bus.fft_sink_ready & ~reset;
            bus.fft_sink_valid = bus.in_valid & ~reset;
            bus.fft_sink_sop   = (r_icnt == '0);
            bus.fft_sink_eop   = w_in_last;
            if (w_in_xfer && w_in_last && !i_cfg_enable) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Direction is only sampled at a frame boundary so a frame never mixes FFT/IFFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_icnt      <= '0;
         r_inverse   <= 1'b0;
         r_frames_in <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_icnt    <= '0;
            r_inverse <= i_cfg_inverse;
         end else if (w_in_xfer) begin
            r_icnt <= r_icnt + 1'b1;
            if (w_in_last) begin
               r_frames_in <= r_frames_in + 16'd1;
               if (i_cfg_enable) begin
                  r_inverse <= i_cfg_inverse;
               end
            end
         end
      end
   end

   assign bus.fft_sink_real  = bus.in_real;
   assign bus.fft_sink_imag  = bus.in_imag;
   assign bus.fft_sink_error = 2'b00;
   assign bus.fft_inverse    = r_inverse;

   assign w_out_xfer = bus.fft_source_valid & bus.out_ready & ~reset;
   assign w_out_bin  = bus.fft_source_sop ? '0 : r_ocnt;

   // A stray sop resynchronises to bin 0 but is still reported as a framing error.
   assign w_framing_err = (bus.fft_source_sop  && (r_ocnt != '0))
                        | (!bus.fft_source_sop && (r_ocnt == '0))
                        | (bus.fft_source_eop  && (w_out_bin != LAST))
                        | (!bus.fft_source_eop && (w_out_bin == LAST));
   assign w_err        = w_out_xfer & (w_framing_err | (bus.fft_source_error != 2'b00));
   assign w_frame_done = w_out_xfer & bus.fft_source_eop & (w_out_bin == LAST);

   assign bus.out_valid        = bus.fft_source_valid & ~reset;
   assign bus.fft_source_ready = bus.out_ready & ~reset;
   assign bus.out_real         = bus.fft_source_real;
   assign bus.out_imag         = bus.fft_source_imag;
   assign bus.out_sop          = bus.fft_source_sop;
   assign bus.out_eop          = bus.fft_source_eop;
   assign bus.out_bin          = w_out_bin;
   assign bus.out_exp          = bus.fft_source_sop ? bus.fft_source_exp : r_exp;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ocnt       <= '0;
         r_exp        <= '0;
         r_frames_out <= '0;
         r_frame_err  <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_frame_err <= w_err;
         if (w_out_xfer) begin
            r_ocnt <= w_out_bin + 1'b1;
            if (bus.fft_source_sop) begin
               r_exp <= bus.fft_source_exp;
            end
         end
         if (w_frame_done) begin
            r_frames_out <= r_frames_out + 16'd1;
         end
         if (w_err) begin
            r_err_sticky <= 1'b1;
         end else if (i_err_clr) begin
            r_err_sticky <= 1'b0;
         end
      end
   end

   assign o_frames_in  = r_frames_in;
   assign o_frames_out = r_frames_out;
   assign o_frame_err  = r_frame_err;
   assign o_err_sticky = r_err_sticky;
   assign o_busy       = (r_state == FRAME) | (r_frames_in != r_frames_out);
endmodule

// File: tb/tb_fft128_frame_ctrl.sv
// Directed scoreboard bench for fft128_frame_ctrl: input framing, direction
// latching, backpressure, output bin/exponent tracking, error flags and reset.
module tb_fft128_frame_ctrl;
   localparam int N = 128;
   localparam int W = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfgEnable, cfgInverse, errClr;
   logic [15:0] framesIn, framesOut;
   logic        frameErr, errSticky, busy;

   fft128_frame_ctrl_if #(.N(N), .W(W)) bus();

   fft128_frame_ctrl #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_cfg_enable (cfgEnable),
      .i_cfg_inverse(cfgInverse),
      .i_err_clr    (errClr),
      .bus          (bus),
      .o_frames_in  (framesIn),
      .o_frames_out (framesOut),
      .o_frame_err  (frameErr),
      .o_err_sticky (errSticky),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         sop;
      logic         eop;
      logic         inv;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } inExp_t;

   typedef struct packed {
      logic [6:0]   bin;
      logic [5:0]   exp;
      logic         sop;
      logic         eop;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } outExp_t;

   inExp_t  inQ[$];
   outExp_t outQ[$];
   int      checks = 0;
   int      errors = 0;
   int      expFramesIn = 0;
   int      expFramesOut = 0;
   logic    expErrPulse = 1'b0;
   logic    expSticky = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkStatus();
      checkOutput("frame_err", frameErr, expErrPulse);
      checkOutput("err_sticky", errSticky, expSticky);
      checkOutput("frames_out", framesOut, 16'(expFramesOut));
   endtask

   // Streams nBeats samples through the input side, starting from IDLE.
   task automatic applyStimulus(input int nBeats, input int stallEvery, input int enDropAt,
                                input int invSetAt, input logic invVal, input logic invFirst);
      int     k = 0;
      int     cycles = 0;
      int     pushed = 0;
      int     fs;
      logic   rdy;
      inExp_t e, got;
      inQ.delete();
      cfgEnable = 1'b1;
      cfgInverse = invFirst;
      bus.in_valid = 1'b1;
      bus.in_real = '0;
      bus.in_imag = '0;
      bus.fft_sink_ready = 1'b1;
      #1;
      checkOutput("idle_sink_valid", bus.fft_sink_valid, 0);
      checkOutput("idle_in_ready", bus.in_ready, 0);
      @(negedge clk);
      while (k < nBeats && cycles < nBeats * 3 + 20) begin
         rdy = !(stallEvery > 0 && (cycles % stallEvery) == stallEvery - 1);
         cfgEnable = !(enDropAt >= 0 && k >= enDropAt);
         cfgInverse = (invSetAt >= 0 && k >= invSetAt) ? invVal : invFirst;
         bus.in_valid = 1'b1;
         bus.in_real = W'(k * 7 + 3);
         bus.in_imag = W'(~k);
         bus.fft_sink_ready = rdy;
         if (pushed == k) begin
            fs = k - (k % N);
            e.sop = (k % N == 0);
            e.eop = (k % N == N - 1);
            e.inv = (invSetAt >= 0 && fs > invSetAt) ? invVal : invFirst;
            e.re = W'(k * 7 + 3);
            e.im = W'(~k);
            inQ.push_back(e);
            pushed++;
         end
         #1;
         checkOutput("frames_in", framesIn, 16'(expFramesIn));
         checkOutput("in_ready", bus.in_ready, rdy);
         checkOutput("sink_valid", bus.fft_sink_valid, 1);
         if (bus.fft_sink_valid && bus.fft_sink_ready && inQ.size() > 0) begin
            got = inQ.pop_front();
            checkOutput("sink_sop", bus.fft_sink_sop, got.sop);
            checkOutput("sink_eop", bus.fft_sink_eop, got.eop);
            checkOutput("fft_inverse", bus.fft_inverse, got.inv);
            checkOutput("sink_real", bus.fft_sink_real, got.re);
            checkOutput("sink_imag", bus.fft_sink_imag, got.im);
            checkOutput("sink_error", bus.fft_sink_error, 0);
            if (got.eop) expFramesIn++;
            k++;
         end
         @(negedge clk);
         cycles++;
      end
      checkOutput("in_beats", k, nBeats);
      if (enDropAt >= 0) begin
         cfgEnable = 1'b0;
         bus.fft_sink_ready = 1'b1;
         #1;
         checkOutput("end_idle_ready", bus.in_ready, 0);
         checkOutput("end_idle_valid", bus.fft_sink_valid, 0);
         checkOutput("end_frames_in", framesIn, 16'(expFramesIn));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   // Offers one source beat, optionally stalled one cycle by out_ready first.
   task automatic sendOutBeat(input logic sop, input logic eop, input logic [1:0] err,
                              input logic [5:0] exp, input logic stall, input logic clr,
                              input logic [6:0] expBin, input logic [5:0] expExp, input logic expErr);
      outExp_t e, got;
      e.bin = expBin;
      e.exp = expExp;
      e.sop = sop;
      e.eop = eop;
      e.re = W'($urandom);
      e.im = W'($urandom);
      bus.fft_source_valid = 1'b1;
      bus.fft_source_sop = sop;
      bus.fft_source_eop = eop;
      bus.fft_source_error = err;
      bus.fft_source_exp = exp;
      bus.fft_source_real = e.re;
      bus.fft_source_imag = e.im;
      outQ.push_back(e);
      if (stall) begin
         bus.out_ready = 1'b0;
         errClr = 1'b0;
         #1;
         checkStatus();
         checkOutput("stall_src_ready", bus.fft_source_ready, 0);
         checkOutput("stall_out_valid", bus.out_valid, 1);
         @(negedge clk);
         expErrPulse = 1'b0;
      end
      bus.out_ready = 1'b1;
      errClr = clr;
      #1;
      checkStatus();
      checkOutput("out_xfer", bus.out_valid & bus.fft_source_ready, 1);
      if (bus.out_valid && bus.fft_source_ready) begin
         got = outQ.pop_front();
         checkOutput("out_bin", bus.out_bin, got.bin);
         checkOutput("out_exp", bus.out_exp, got.exp);
         checkOutput("out_sop", bus.out_sop, got.sop);
         checkOutput("out_eop", bus.out_eop, got.eop);
         checkOutput("out_real", bus.out_real, got.re);
         checkOutput("out_imag", bus.out_imag, got.im);
      end else begin
         outQ.delete();
      end
      @(negedge clk);
      expErrPulse = expErr;
      if (expErr) expSticky = 1'b1;
      else if (clr) expSticky = 1'b0;
      if (eop && expBin == 7'd127) expFramesOut++;
      bus.fft_source_valid = 1'b0;
      errClr = 1'b0;
   endtask

   task automatic outIdleCheck();
      bus.fft_source_valid = 1'b0;
      #1;
      checkStatus();
      @(negedge clk);
      expErrPulse = 1'b0;
   endtask

   task automatic sendFrame(input logic [5:0] exp);
      for (int j = 0; j < N; j++) begin
         sendOutBeat(j == 0, j == N - 1, 2'b00, (j == 0) ? exp : 6'h2A, (j % 7) == 3, 1'b0,
                     7'(j), exp, 1'b0);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      cfgEnable = 1'b0;
      bus.in_valid = 1'b1;
      bus.fft_sink_ready = 1'b1;
      bus.fft_source_valid = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("rst_in_ready", bus.in_ready, 0);
      checkOutput("rst_sink_valid", bus.fft_sink_valid, 0);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_src_ready", bus.fft_source_ready, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.fft_source_valid = 1'b0;
      bus.fft_source_sop = 1'b0;
      bus.fft_source_exp = 6'h2A;
      #1;
      checkOutput("rst_frames_in", framesIn, 0);
      checkOutput("rst_frames_out", framesOut, 0);
      checkOutput("rst_frame_err", frameErr, 0);
      checkOutput("rst_err_sticky", errSticky, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_fft_inverse", bus.fft_inverse, 0);
      checkOutput("rst_out_bin", bus.out_bin, 0);
      checkOutput("rst_out_exp", bus.out_exp, 0);
      @(negedge clk);
      expFramesIn = 0;
      expFramesOut = 0;
      expErrPulse = 1'b0;
      expSticky = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      cfgEnable = 1'b0;
      cfgInverse = 1'b0;
      errClr = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_real = '0;
      bus.in_imag = '0;
      bus.fft_sink_ready = 1'b0;
      bus.fft_source_valid = 1'b0;
      bus.fft_source_sop = 1'b0;
      bus.fft_source_eop = 1'b0;
      bus.fft_source_error = 2'b00;
      bus.fft_source_exp = '0;
      bus.fft_source_real = '0;
      bus.fft_source_imag = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      doReset();

      applyStimulus(128, 0, 64, -1, 1'b0, 1'b0);
      #1;
      checkOutput("busy_in_flight", busy, 1);
      @(negedge clk);
      applyStimulus(256, 0, 200, 40, 1'b1, 1'b0);
      applyStimulus(256, 3, 200, -1, 1'b0, 1'b1);

      sendFrame(6'd5);
      sendFrame(6'h3D);
      outIdleCheck();

      // Stray sop at bin 60, then a missing eop at bin 127.
      for (int j = 0; j < 60; j++) begin
         sendOutBeat(j == 0, 1'b0, 2'b00, (j == 0) ? 6'd1 : 6'h15, 1'b0, 1'b0, 7'(j), 6'd1, 1'b0);
      end
      sendOutBeat(1'b1, 1'b0, 2'b00, 6'd9, 1'b0, 1'b0, 7'd0, 6'd9, 1'b1);
      for (int j = 1; j < N; j++) begin
         sendOutBeat(1'b0, 1'b0, 2'b00, 6'h15, 1'b0, 1'b0, 7'(j), 6'd9, j == N - 1);
      end
      sendOutBeat(1'b1, 1'b0, 2'b00, 6'd4, 1'b0, 1'b1, 7'd0, 6'd4, 1'b0);
      sendOutBeat(1'b0, 1'b0, 2'b01, 6'h15, 1'b0, 1'b0, 7'd1, 6'd4, 1'b1);
      sendOutBeat(1'b0, 1'b0, 2'b01, 6'h15, 1'b0, 1'b1, 7'd2, 6'd4, 1'b1);
      sendOutBeat(1'b0, 1'b0, 2'b00, 6'h15, 1'b0, 1'b1, 7'd3, 6'd4, 1'b0);
      outIdleCheck();

      applyStimulus(70, 0, -1, -1, 1'b0, 1'b0);
      #1;
      checkOutput("busy_mid_frame", busy, 1);
      @(negedge clk);
      doReset();
      sendOutBeat(1'b0, 1'b0, 2'b00, 6'h11, 1'b0, 1'b0, 7'd0, 6'd0, 1'b1);
      outIdleCheck();
      applyStimulus(128, 0, 64, -1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
